half_adder: RTL and testbench

- Registered, lane-parallel half adder.
- Each of WIDTH independent 1-bit lanes computes sum = a XOR b and carry = a AND b.
- Results are registered one clock after a qualified input.
- Used as a primitive building block for adder trees and checkers in synchronous datapaths. It also provides a carry-activity flag and a saturating carry-event counter for debug.

---
 rtl/half_adder.sv | 58 +++++
 tb/tb_half_adder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// Registered lane-parallel half adder with carry
// activity flag and saturating carry-event counter.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  output logic             carry_any,
  output logic [CNT_W-1:0] carry_count
);

  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;
  logic             w_carry_evt;
  logic             w_cnt_max;

  assign w_sum       = a ^ b;
  assign w_carry     = a & b;
  assign w_carry_evt = |w_carry;
  assign w_cnt_max   = &r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
        // saturate rather than wrap
        if (w_carry_evt && !w_cnt_max)
          r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sum         = r_sum;
  assign carry       = r_carry;
  assign out_valid   = r_valid;
  assign carry_any   = |r_carry;
  assign carry_count = r_cnt;

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder:
// narrow (WIDTH=1,CNT_W=8) and wide (WIDTH=4,CNT_W=2).
module tb_half_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       a, b;
  logic [3:0] wa, wb;

  logic       n_sum, n_carry, n_ov, n_cany;
  logic [7:0] n_cnt;
  logic [3:0] w_sum, w_carry;
  logic       w_ov, w_cany;
  logic [1:0] w_cnt;

  int checks = 0;
  int errors = 0;

  half_adder #(.WIDTH(1), .CNT_W(8)) u_n (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b),
    .sum(n_sum), .carry(n_carry), .out_valid(n_ov),
    .carry_any(n_cany), .carry_count(n_cnt)
  );

  half_adder #(.WIDTH(4), .CNT_W(2)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(wa), .b(wb),
    .sum(w_sum), .carry(w_carry), .out_valid(w_ov),
    .carry_any(w_cany), .carry_count(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; a = 0; b = 0; wa = 0; wb = 0;
    tick();
    tick();
    checks++; if (n_sum !== 1'b0) begin errors++; $display("FAIL rst_sum got %0h exp 0", n_sum); end
    checks++; if (n_carry !== 1'b0) begin errors++; $display("FAIL rst_carry got %0h exp 0", n_carry); end
    checks++; if (n_ov !== 1'b0) begin errors++; $display("FAIL rst_ov got %0h exp 0", n_ov); end
    checks++; if (n_cany !== 1'b0) begin errors++; $display("FAIL rst_cany got %0h exp 0", n_cany); end
    checks++; if (n_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", n_cnt); end
    checks++; if (w_sum !== 4'h0 || w_carry !== 4'h0) begin errors++; $display("FAIL rst_wide got %h/%h exp 0/0", w_sum, w_carry); end
    rst = 0;
  endtask

  task automatic test_zero();
    in_valid = 1; a = 0; b = 0;
    tick();
    in_valid = 0;
    checks++; if (n_sum !== 1'b0) begin errors++; $display("FAIL zero_sum got %0h exp 0", n_sum); end
    checks++; if (n_carry !== 1'b0) begin errors++; $display("FAIL zero_carry got %0h exp 0", n_carry); end
    checks++; if (n_ov !== 1'b1) begin errors++; $display("FAIL zero_ov got %0h exp 1", n_ov); end
    checks++; if (n_cnt !== 8'd0) begin errors++; $display("FAIL zero_cnt got %0d exp 0", n_cnt); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1; a = 0; b = 1;
    tick();
    a = 1; b = 0;
    checks++; if (n_sum !== 1'b1 || n_carry !== 1'b0) begin errors++; $display("FAIL b2b0_sc got %0h/%0h exp 1/0", n_sum, n_carry); end
    checks++; if (n_ov !== 1'b1 || n_cany !== 1'b0) begin errors++; $display("FAIL b2b0_ov got %0h/%0h exp 1/0", n_ov, n_cany); end
    tick();
    in_valid = 0;
    checks++; if (n_sum !== 1'b1 || n_carry !== 1'b0) begin errors++; $display("FAIL b2b1_sc got %0h/%0h exp 1/0", n_sum, n_carry); end
    checks++; if (n_ov !== 1'b1 || n_cany !== 1'b0) begin errors++; $display("FAIL b2b1_ov got %0h/%0h exp 1/0", n_ov, n_cany); end
  endtask

  task automatic test_carry();
    in_valid = 1; a = 1; b = 1;
    tick();
    in_valid = 0; a = 0; b = 0;
    checks++; if (n_sum !== 1'b0 || n_carry !== 1'b1) begin errors++; $display("FAIL cy_sc got %0h/%0h exp 0/1", n_sum, n_carry); end
    checks++; if (n_cany !== 1'b1) begin errors++; $display("FAIL cy_cany got %0h exp 1", n_cany); end
    checks++; if (n_cnt !== 8'd1) begin errors++; $display("FAIL cy_cnt got %0d exp 1", n_cnt); end
    tick();
    checks++; if (n_ov !== 1'b0) begin errors++; $display("FAIL idle_ov got %0h exp 0", n_ov); end
    checks++; if (n_sum !== 1'b0 || n_carry !== 1'b1) begin errors++; $display("FAIL idle_hold got %0h/%0h exp 0/1", n_sum, n_carry); end
    checks++; if (n_cnt !== 8'd1) begin errors++; $display("FAIL idle_cnt got %0d exp 1", n_cnt); end
  endtask

  task automatic test_saturate();
    logic [1:0] wexp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [7:0] nexp;
    rst = 1; in_valid = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; a = 1; b = 1; wa = 4'b0001; wb = 4'b0011;
      tick();
      nexp = 8'(i + 1);
      checks++; if (w_cnt !== wexp[i]) begin errors++; $display("FAIL sat_w%0d got %0d exp %0d", i, w_cnt, wexp[i]); end
      checks++; if (n_cnt !== nexp) begin errors++; $display("FAIL sat_n%0d got %0d exp %0d", i, n_cnt, nexp); end
    end
    in_valid = 0;
    tick();
    checks++; if (w_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", w_cnt); end
  endtask

  task automatic test_wide();
    in_valid = 1; a = 0; b = 0; wa = 4'b1100; wb = 4'b1010;
    tick();
    in_valid = 0;
    checks++; if (w_sum !== 4'b0110) begin errors++; $display("FAIL wide_sum got %b exp 0110", w_sum); end
    checks++; if (w_carry !== 4'b1000) begin errors++; $display("FAIL wide_carry got %b exp 1000", w_carry); end
    checks++; if (w_cany !== 1'b1 || w_ov !== 1'b1) begin errors++; $display("FAIL wide_flags got %0h/%0h exp 1/1", w_cany, w_ov); end
    in_valid = 1; wa = 4'b0101; wb = 4'b1010;
    tick();
    in_valid = 0;
    checks++; if (w_sum !== 4'b1111 || w_cany !== 1'b0) begin errors++; $display("FAIL wide_nocy got %b/%0h exp 1111/0", w_sum, w_cany); end
  endtask

  task automatic test_reset_stream();
    in_valid = 1; a = 1; b = 1; wa = 4'hF; wb = 4'hF;
    tick();
    rst = 1;
    tick();
    rst = 0; in_valid = 0;
    checks++; if (n_ov !== 1'b0 || w_ov !== 1'b0) begin errors++; $display("FAIL rs_ov got %0h/%0h exp 0/0", n_ov, w_ov); end
    checks++; if (n_sum !== 1'b0 || n_carry !== 1'b0) begin errors++; $display("FAIL rs_sc got %0h/%0h exp 0/0", n_sum, n_carry); end
    checks++; if (w_carry !== 4'h0 || w_sum !== 4'h0) begin errors++; $display("FAIL rs_wide got %h/%h exp 0/0", w_sum, w_carry); end
    checks++; if (n_cnt !== 8'd0 || w_cnt !== 2'd0) begin errors++; $display("FAIL rs_cnt got %0d/%0d exp 0/0", n_cnt, w_cnt); end
    tick();
    checks++; if (n_ov !== 1'b0) begin errors++; $display("FAIL rs_after got %0h exp 0", n_ov); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_back_to_back();
    test_carry();
    test_saturate();
    test_wide();
    test_reset_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
